accel_pair_feeder: RTL and testbench

Upstream issue stage for the `getAccl` gravity-acceleration pipeline. Holds a table of `NBODIES` bodies (x, y, mass; IEEE-754 double) loaded by the host. On `start`, it streams every ordered pair (i, j) with i ≠ j into `getAccl`, one pair per cycle. A tag delay line matched to `getAccl`'s fixed latency marks which `ax`/`ay` outputs are valid, which body they belong to, and which is the last term for that body, so the downstream accumulator can consume them directly.

---
 rtl/accel_pair_feeder.sv | 179 +++++++++++++++++
 tb/tb_accel_pair_feeder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/accel_pair_feeder.sv
// accel_pair_feeder
//   Issue stage for the getAccl gravity pipeline. Holds a host-loaded table of
//   NBODIES bodies (x, y, m as IEEE-754 double bits). On start it streams every
//   ordered pair (i, j), i != j, into getAccl at one pair per cycle. A tag delay
//   line matched to getAccl's latency flags the valid results, their target body
//   and the last term per body.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   wr_en/wr_addr/wr_x/y/m   body table write (dropped while busy)
//   start                    begin a pass (ignored while busy)
//   busy, done               pass in progress / one-cycle end-of-pass pulse
//   x1, y1                   target body i to getAccl
//   x2, y2, m2               source body j to getAccl
//   issue_valid              x1..m2 hold a real pair
//   res_valid/res_idx/res_last  tags aligned to getAccl ax/ay
module accel_pair_feeder #(
    parameter int NBODIES = 4,
    parameter int IDX_W   = $clog2(NBODIES),
    parameter int LATENCY = 122
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [63:0]      wr_x,
    input  logic [63:0]      wr_y,
    input  logic [63:0]      wr_m,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [63:0]      x1,
    output logic [63:0]      y1,
    output logic [63:0]      x2,
    output logic [63:0]      y2,
    output logic [63:0]      m2,
    output logic             issue_valid,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_last
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBODIES - 1);

    typedef struct packed {
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] m;
    } body_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             last;
    } tag_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    body_t            tbl [NBODIES];
    state_t           state;
    logic [IDX_W-1:0] i_q, j_q;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] tag_idx;
    logic             tag_last;
    tag_t             tag_pipe [LATENCY];

    // Body table: deliberately outside reset so a mid-pass reset keeps the data.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            tbl[wr_addr] <= '{x: wr_x, y: wr_y, m: wr_m};
    end

    // Pair sequencing: step j over all indices except i; on wrap move to i+1.
    logic [IDX_W:0]   j_inc;
    logic [IDX_W-1:0] i_nxt, j_nxt;
    logic             pair_last, pass_end;

    always_comb begin
        j_inc = {1'b0, j_q} + 1'b1;
        if (j_inc == {1'b0, i_q})
            j_inc = j_inc + 1'b1;
        pair_last = (j_inc >= (IDX_W + 1)'(NBODIES));
        pass_end  = pair_last && (i_q == LAST_IDX);
        if (pair_last) begin
            // the next i is always >= 1, so its first source index is 0
            i_nxt = i_q + 1'b1;
            j_nxt = '0;
        end else begin
            i_nxt = i_q;
            j_nxt = j_inc[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            x1          <= '0;
            y1          <= '0;
            x2          <= '0;
            y2          <= '0;
            m2          <= '0;
            issue_valid <= 1'b0;
            tag_idx     <= '0;
            tag_last    <= 1'b0;
        end else begin
            // outside ISSUE the operands are +0.0, so m2 = 0 gives zero force
            done        <= 1'b0;
            x1          <= '0;
            y1          <= '0;
            x2          <= '0;
            y2          <= '0;
            m2          <= '0;
            issue_valid <= 1'b0;
            tag_idx     <= '0;
            tag_last    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        i_q   <= '0;
                        j_q   <= IDX_W'(1);
                    end
                end
                ISSUE: begin
                    x1          <= tbl[i_q].x;
                    y1          <= tbl[i_q].y;
                    x2          <= tbl[j_q].x;
                    y2          <= tbl[j_q].y;
                    m2          <= tbl[j_q].m;
                    issue_valid <= 1'b1;
                    tag_idx     <= i_q;
                    tag_last    <= pair_last;
                    if (pass_end) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        i_q <= i_nxt;
                        j_q <= j_nxt;
                    end
                end
                DRAIN: begin
                    // LATENCY+1 drain edges: the final tag leaves the line on the last one
                    if (cnt == CNT_W'(LATENCY)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag delay line, fed from the registered issue outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LATENCY; k++)
                tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{vld: issue_valid, idx: tag_idx, last: tag_last};
            for (int k = 1; k < LATENCY; k++)
                tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign res_valid = tag_pipe[LATENCY-1].vld;
    assign res_idx   = tag_pipe[LATENCY-1].idx;
    assign res_last  = tag_pipe[LATENCY-1].last;

endmodule

// File: tb/tb_accel_pair_feeder.sv
// Directed bench for accel_pair_feeder (N=4, LATENCY=122).
module tb_accel_pair_feeder;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int LAT = 122;
    localparam int NP  = N * (N - 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [63:0]   wr_x = '0, wr_y = '0, wr_m = '0;
    logic          start = 1'b0;
    logic          busy, done, issue_valid, res_valid, res_last;
    logic [63:0]   x1, y1, x2, y2, m2;
    logic [IW-1:0] res_idx;

    accel_pair_feeder #(.NBODIES(N), .IDX_W(IW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .start(start),
        .busy(busy), .done(done), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2),
        .issue_valid(issue_valid), .res_valid(res_valid), .res_idx(res_idx),
        .res_last(res_last)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // bench-side copy of the table contents
    logic [63:0] mx [N];
    logic [63:0] my [N];
    logic [63:0] mm [N];

    // hand-written issue order for N=4
    int ei [NP] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    int ej [NP] = '{1, 2, 3, 0, 2, 3, 0, 1, 3, 0, 1, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, " x1"}, x1, 64'h0);
        chk({tag, " y1"}, y1, 64'h0);
        chk({tag, " x2"}, x2, 64'h0);
        chk({tag, " y2"}, y2, 64'h0);
        chk({tag, " m2"}, m2, 64'h0);
        chk({tag, " busy"}, {63'h0, busy}, 64'h0);
        chk({tag, " done"}, {63'h0, done}, 64'h0);
        chk({tag, " iv"}, {63'h0, issue_valid}, 64'h0);
        chk({tag, " rv"}, {63'h0, res_valid}, 64'h0);
        chk({tag, " ridx"}, {62'h0, res_idx}, 64'h0);
        chk({tag, " rlast"}, {63'h0, res_last}, 64'h0);
    endtask

    task automatic load_table();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            mx[i] = $realtobits(10.0 * i);
            my[i] = $realtobits(-10.0 * i);
            mm[i] = $realtobits(100.0 + i);
            wr_en = 1'b1; wr_addr = IW'(i);
            wr_x = mx[i]; wr_y = my[i]; wr_m = mm[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Quiet window: count res_valid / done over a number of cycles.
    task automatic quiet(input string tag, input int cycles);
        int rv_cnt, d_cnt;
        rv_cnt = 0; d_cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (res_valid) rv_cnt++;
            if (done) d_cnt++;
        end
        chk({tag, " res_valid count"}, 64'(rv_cnt), 64'd0);
        chk({tag, " done count"}, 64'(d_cnt), 64'd0);
        chk({tag, " busy"}, {63'h0, busy}, 64'h0);
    endtask

    // One full pass. n counts edges after the start edge T; sampling on negedge.
    task automatic run_pass(input string tag, input bit inject, input bit wrs, input bit spot);
        int d_cnt;
        int k;
        d_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        if (wrs) begin
            mx[1] = $realtobits(7.0);
            wr_en = 1'b1; wr_addr = 2'd1;
            wr_x = mx[1]; wr_y = my[1]; wr_m = mm[1];
        end
        @(posedge clk);
        for (int n = 0; n <= LAT + NP + 6; n++) begin
            @(negedge clk);
            if (n == 0 || n == 4) begin start = 1'b0; wr_en = 1'b0; end
            if (done) d_cnt++;
            if (n == 0)
                chk($sformatf("%s busy after start", tag), {63'h0, busy}, 64'h1);
            if (n >= 1 && n <= NP) begin
                k = n - 1;
                chk($sformatf("%s iv[%0d]", tag, k), {63'h0, issue_valid}, 64'h1);
                chk($sformatf("%s x1[%0d]", tag, k), x1, mx[ei[k]]);
                chk($sformatf("%s y1[%0d]", tag, k), y1, my[ei[k]]);
                chk($sformatf("%s x2[%0d]", tag, k), x2, mx[ej[k]]);
                chk($sformatf("%s y2[%0d]", tag, k), y2, my[ej[k]]);
                chk($sformatf("%s m2[%0d]", tag, k), m2, mm[ej[k]]);
            end
            if (spot && n == 4) begin
                chk({tag, " spot x1"}, x1, $realtobits(10.0));
                chk({tag, " spot x2"}, x2, $realtobits(0.0));
                chk({tag, " spot m2"}, m2, $realtobits(100.0));
            end
            if (wrs && n == 1)
                chk({tag, " first x2"}, x2, $realtobits(7.0));
            if (n == NP + 1) begin
                chk({tag, " iv after"}, {63'h0, issue_valid}, 64'h0);
                chk({tag, " x1 after"}, x1, 64'h0);
                chk({tag, " y2 after"}, y2, 64'h0);
                chk({tag, " m2 after"}, m2, 64'h0);
            end
            if (n >= LAT + 1 && n <= LAT + NP) begin
                k = n - LAT - 1;
                chk($sformatf("%s rv[%0d]", tag, k), {63'h0, res_valid}, 64'h1);
                chk($sformatf("%s ridx[%0d]", tag, k), {62'h0, res_idx}, 64'(ei[k]));
                chk($sformatf("%s rlast[%0d]", tag, k), {63'h0, res_last},
                    64'((k % 3) == 2));
            end
            if (n == LAT || n == LAT + NP + 1)
                chk($sformatf("%s rv edge n=%0d", tag, n), {63'h0, res_valid}, 64'h0);
            if (n == LAT + NP) begin
                chk({tag, " done early"}, {63'h0, done}, 64'h0);
                chk({tag, " busy before end"}, {63'h0, busy}, 64'h1);
            end
            if (n == LAT + NP + 1) begin
                chk({tag, " done"}, {63'h0, done}, 64'h1);
                chk({tag, " busy at done"}, {63'h0, busy}, 64'h0);
            end
            if (n == LAT + NP + 2)
                chk({tag, " done low"}, {63'h0, done}, 64'h0);
            if (inject && n == 3) begin
                start = 1'b1;
                wr_en = 1'b1; wr_addr = 2'd0; wr_x = $realtobits(99.0);
            end
        end
        chk({tag, " done count"}, 64'(d_cnt), 64'd1);
    endtask

    initial begin
        // reset
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_zero_outs("reset");
        rst = 1'b1;
        quiet("post-reset", 200);

        load_table();
        run_pass("order", 1'b0, 1'b0, 1'b1);
        run_pass("ignored", 1'b1, 1'b0, 1'b0);
        run_pass("after-ignored", 1'b0, 1'b0, 1'b1);

        // mid-pass reset at pair 5
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst pair5 iv", {63'h0, issue_valid}, 64'h1);
        chk("midrst pair5 x1", x1, mx[1]);
        #2 rst = 1'b0;
        #1;
        chk_zero_outs("midrst async");
        @(negedge clk);
        rst = 1'b1;
        quiet("midrst", 200);
        run_pass("after-midrst", 1'b0, 1'b0, 1'b1);

        run_pass("wr+start", 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
